stroke_interpolator: RTL
========================

// Module: stroke_interpolator
// PURPOSE
//  Sits directly upstream of the frame buffer and drives its brush position (x_in/y_in).
//  Accepts sparse cursor samples and walks a Bresenham line from the current brush position
//  to each new sample. It advances one pixel per video frame, so painted strokes have no gaps.
//  Pen-up samples relocate the brush without painting.
// PARAMETERS
//  H_RES  640  horizontal resolution; x is clamped to H_RES-1
//  V_RES  360  vertical resolution; y is clamped to V_RES-1
// PORTS
//  pixel_clk_in      in   1   pixel clock; the only clock
//  rst_in            in   1   synchronous reset, active-low
//  nf_in             in   1   new-frame strobe, 1-cycle pulse per frame
//  sample_valid_in   in   1   cursor sample valid
//  sample_ready_out  out  1   block can accept a sample
//  sample_x_in       in   10  sample x, unsigned
//  sample_y_in       in   9   sample y, unsigned
//  pen_down_in       in   1   1 = paint toward sample; 0 = move without painting
//  x_out             out  10  brush x, to frame buffer x_in
//  y_out             out  9   brush y, to frame buffer y_in
//  draw_out          out  1   brush paints (gates frame buffer write)
//  busy_out          out  1   a jump or line is in progress
// BEHAVIOUR
//  Reset (rst_in==0 at a clock edge)
//   - x_out=0, y_out=0, draw_out=0, state=IDLE, has_prev=0.
//   - Aborts any line in progress; a pending target is discarded.
//  Handshake
//   - A sample is accepted when sample_valid_in && sample_ready_out in the same cycle.
//   - sample_ready_out = (state==IDLE); busy_out = (state!=IDLE). Both are combinational from state.
//   - On acceptance, clamp: tx = min(sample_x_in, H_RES-1); ty = min(sample_y_in, V_RES-1).
//   - Register tx, ty and the pen state.
//  States: IDLE, JUMP, LINE
//   IDLE -> JUMP on acceptance if pen_down_in==0 or has_prev==0.
//   IDLE -> LINE on acceptance if pen_down_in==1 and has_prev==1, and (tx,ty)!=(x_out,y_out).
//   IDLE -> IDLE on acceptance if pen_down && has_prev && target == current position.
//   JUMP: on the next nf_in, x_out=tx, y_out=ty, draw_out=pen, has_prev=pen; -> IDLE.
//   LINE: on each nf_in, apply one Bresenham step.
//     - Set draw_out=1.
//     - Go to IDLE in the same cycle the new position equals (tx,ty).
//  Bresenham arithmetic (signed)
//   - Setup is computed combinationally at acceptance from the current x_out/y_out.
//     No separate setup cycle, so no nf_in is lost.
//   - dx = |tx-x| (11b); dy = -|ty-y| (11b); sx, sy = +/-1; err = dx+dy (12b).
//   - Per step: e2 = 2*err (13b).
//     - If e2 >= dy: err += dy, x += sx.
//     - If e2 <= dx: err += dx, y += sy. Both may apply in the same step.
//   - Coordinates never leave [0,H_RES-1] x [0,V_RES-1].
//  Timing
//   - Outputs change only on the clock edge where nf_in==1.
//   - New values are visible the cycle after the nf_in pulse.
//   - Outputs are held stable for the whole frame, so the frame buffer paints one disc per frame.
//  Simultaneous and edge events
//   - nf_in in IDLE (including the acceptance cycle): no output change.
//   - sample_valid_in while busy: not accepted; the source must hold it.
//   - After a pen-down line ends, draw_out stays 1 (brush keeps painting at rest).
//     It clears only when a pen-up JUMP completes.
// TESTING
//  1. Reset
//     - Stimulus: rst_in=0 for 2 cycles.
//     - Expect: x_out=0, y_out=0, draw_out=0, sample_ready_out=1, busy_out=0.
//  2. First pen-down sample (100,50)
//     - Expect: ready drops next cycle; outputs unchanged until nf_in.
//     - Cycle after nf_in: x=100, y=50, draw=1, ready=1.
//  3. Then pen-down (104,50) with 4 nf_in pulses
//     - Expect: x steps 101, 102, 103, 104; y=50.
//     - busy_out falls with the 4th step; extra nf_in pulses cause no change.
//  4. From (100,50), pen-down (103,52)
//     - Expect: 3 steps (101,51) -> (102,51) -> (103,52).
//  5. Pen-up sample (700,400)
//     - Expect: after nf_in, x=639, y=359, draw=0.
//     - Then pen-down (639,350): after nf_in, jump to (639,350) with draw=1; no line is drawn.
//  6. Reset mid-line
//     - Stimulus: during test 3 after 2 steps, rst_in=0 for 1 cycle.
//     - Expect: outputs 0, ready=1.
//     - Next pen-down (10,10) jumps to (10,10); no line from (0,0).

Source files
------------

// File: rtl/stroke_interpolator.sv
// Brush-position driver for the frame buffer: walks a Bresenham line toward each
// accepted cursor sample, one pixel per video frame, or jumps there when the pen is up.
module stroke_interpolator #(
    parameter int H_RES = 640,
    parameter int V_RES = 360
) (
    input  logic       pixel_clk_in,
    input  logic       rst_in,
    input  logic       nf_in,
    input  logic       sample_valid_in,
    output logic       sample_ready_out,
    input  logic [9:0] sample_x_in,
    input  logic [8:0] sample_y_in,
    input  logic       pen_down_in,
    output logic [9:0] x_out,
    output logic [8:0] y_out,
    output logic       draw_out,
    output logic       busy_out
);

    // Handshake: a sample transfers on a clock edge where sample_valid_in and
    // sample_ready_out are both high; the source holds valid and data until then.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        JUMP = 2'd1,
        LINE = 2'd2
    } state_t;

    localparam logic [9:0] X_MAX = 10'(H_RES - 1);
    localparam logic [8:0] Y_MAX = 9'(V_RES - 1);

    state_t state;
    state_t state_next;

    logic has_prev;
    logic pen_r;
    logic [9:0] tx_r;
    logic [8:0] ty_r;
    logic signed [11:0] dx_r;
    logic signed [11:0] dy_r;
    logic signed [11:0] err_r;
    logic sx_neg_r;
    logic sy_neg_r;

    logic accept;
    logic [9:0] tx_c;
    logic [8:0] ty_c;
    logic same_pos;

    logic signed [10:0] ddx;
    logic signed [10:0] ddy;
    logic signed [10:0] adx;
    logic signed [10:0] ady;
    logic signed [10:0] ndy;
    logic signed [11:0] dx_c;
    logic signed [11:0] dy_c;
    logic signed [11:0] err_c;

    logic signed [12:0] e2;
    logic signed [12:0] dx_13;
    logic signed [12:0] dy_13;
    logic step_x;
    logic step_y;
    logic signed [11:0] err_step;
    logic [9:0] x_step;
    logic [8:0] y_step;
    logic line_done;

    assign accept   = sample_valid_in && sample_ready_out;
    assign tx_c     = (sample_x_in > X_MAX) ? X_MAX : sample_x_in;
    assign ty_c     = (sample_y_in > Y_MAX) ? Y_MAX : sample_y_in;
    assign same_pos = (tx_c == x_out) && (ty_c == y_out);

    // Line setup is taken from the live brush position in the acceptance cycle,
    // so the first step can happen on the very next nf_in.
    always_comb begin
        ddx   = $signed({1'b0, tx_c}) - $signed({1'b0, x_out});
        ddy   = $signed({2'b00, ty_c}) - $signed({2'b00, y_out});
        adx   = ddx[10] ? -ddx : ddx;
        ady   = ddy[10] ? -ddy : ddy;
        ndy   = -ady;
        dx_c  = $signed({adx[10], adx});
        dy_c  = $signed({ndy[10], ndy});
        err_c = dx_c + dy_c;
    end

    always_comb begin
        e2       = $signed({err_r, 1'b0});
        dx_13    = $signed({dx_r[11], dx_r});
        dy_13    = $signed({dy_r[11], dy_r});
        step_x   = (e2 >= dy_13);
        step_y   = (e2 <= dx_13);
        err_step = err_r;
        if (step_x) begin
            err_step = err_step + dy_r;
        end
        if (step_y) begin
            err_step = err_step + dx_r;
        end

        x_step = x_out;
        if (step_x) begin
            if (sx_neg_r) begin
                x_step = (x_out == 10'd0) ? 10'd0 : x_out - 10'd1;
            end else begin
                x_step = (x_out == X_MAX) ? X_MAX : x_out + 10'd1;
            end
        end

        y_step = y_out;
        if (step_y) begin
            if (sy_neg_r) begin
                y_step = (y_out == 9'd0) ? 9'd0 : y_out - 9'd1;
            end else begin
                y_step = (y_out == Y_MAX) ? Y_MAX : y_out + 9'd1;
            end
        end

        line_done = (x_step == tx_r) && (y_step == ty_r);
    end

    always_ff @(posedge pixel_clk_in) begin
        if (!rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!pen_down_in || !has_prev) begin
                        state_next = JUMP;
                    end else if (!same_pos) begin
                        state_next = LINE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            JUMP: begin
                if (nf_in) begin
                    state_next = IDLE;
                end
            end
            LINE: begin
                if (nf_in && line_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sample_ready_out = (state == IDLE);
        busy_out         = (state != IDLE);
    end

    // Brush outputs move only on nf_in edges so each frame sees one stable disc.
    always_ff @(posedge pixel_clk_in) begin
        if (!rst_in) begin
            x_out    <= 10'd0;
            y_out    <= 9'd0;
            draw_out <= 1'b0;
            has_prev <= 1'b0;
            pen_r    <= 1'b0;
            tx_r     <= 10'd0;
            ty_r     <= 9'd0;
            dx_r     <= 12'sd0;
            dy_r     <= 12'sd0;
            err_r    <= 12'sd0;
            sx_neg_r <= 1'b0;
            sy_neg_r <= 1'b0;
        end else begin
            if (accept) begin
                tx_r     <= tx_c;
                ty_r     <= ty_c;
                pen_r    <= pen_down_in;
                dx_r     <= dx_c;
                dy_r     <= dy_c;
                err_r    <= err_c;
                sx_neg_r <= ddx[10];
                sy_neg_r <= ddy[10];
            end
            case (state)
                JUMP: begin
                    if (nf_in) begin
                        x_out    <= tx_r;
                        y_out    <= ty_r;
                        draw_out <= pen_r;
                        has_prev <= pen_r;
                    end
                end
                LINE: begin
                    if (nf_in) begin
                        x_out    <= x_step;
                        y_out    <= y_step;
                        err_r    <= err_step;
                        draw_out <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
